// File: rtl/acc_pkg.sv
// Shared encodings and reset defaults for the accumulator execute stage.
// Optional feature macro used by the design files: ACC_EXEC_OVF_EN.
package acc_pkg;

  // ALU A operand select
  localparam logic [1:0] SRCA_PC   = 2'd0;
  localparam logic [1:0] SRCA_ACC  = 2'd1;
  localparam logic [1:0] SRCA_SP   = 2'd2;
  localparam logic [1:0] SRCA_ZERO = 2'd3;

  // ALU B operand select; codes 6 and 7 give zero
  localparam logic [2:0] SRCB_MDR     = 3'd0;
  localparam logic [2:0] SRCB_TWO     = 3'd1;
  localparam logic [2:0] SRCB_SEXT    = 3'd2;
  localparam logic [2:0] SRCB_ZEXT    = 3'd3;
  localparam logic [2:0] SRCB_HI      = 3'd4;
  localparam logic [2:0] SRCB_SEXT_SH = 3'd5;

  // ALU function
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_AND = 2'd3;

  // ACC write-data select; codes 5..7 hold ACC
  localparam logic [2:0] ACCSRC_ALUOUT = 3'd0;
  localparam logic [2:0] ACCSRC_MDR    = 3'd1;
  localparam logic [2:0] ACCSRC_IO     = 3'd2;
  localparam logic [2:0] ACCSRC_LT     = 3'd3;
  localparam logic [2:0] ACCSRC_R      = 3'd4;

  // Next-PC select
  localparam logic [1:0] PCSRC_R      = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_ACC    = 2'd3;

  // Architectural reset values
  localparam logic [15:0] SP_INIT_DEFAULT = 16'h07fe;
  localparam logic [15:0] PC_INIT_DEFAULT = 16'h0000;

  // Sign-extend the 10-bit immediate/target field to the datapath width
  function automatic logic [15:0] sext10(input logic [9:0] v);
    return {{6{v[9]}}, v};
  endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational 16-bit ALU: add, subtract, or, and, plus signed compare.
// The overflow output is only computed when ACC_EXEC_OVF_EN is defined;
// otherwise it is a constant 0.
module acc_alu
  import acc_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [1:0]  op,
  output logic [15:0] r,
  output logic        lt,
  output logic        ovf
);

  // Result select; arithmetic wraps modulo 2^16
  always_comb begin
    r = 16'h0000;
    unique case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_OR:  r = a | b;
      ALU_AND: r = a & b;
      default: r = 16'h0000;
    endcase
  end

  // Full-precision signed compare, independent of the sign of r
  always_comb begin
    lt = ($signed(a) < $signed(b));
  end

`ifdef ACC_EXEC_OVF_EN
  // Signed overflow: operands of matching effective sign give a result of the other sign
  always_comb begin
    ovf = 1'b0;
    unique case (op)
      ALU_ADD: ovf = (a[15] == b[15]) && (r[15] != a[15]);
      ALU_SUB: ovf = (a[15] != b[15]) && (r[15] != a[15]);
      default: ovf = 1'b0;
    endcase
  end
`else
  // Overflow detection not built
  always_comb begin
    ovf = 1'b0;
  end
`endif

endmodule

// File: rtl/acc_execute.sv
// Execute/writeback stage of the accumulator processor. Owns PC, ACC, SP,
// ALUOut, Zero and the signed less-than flag. The sticky overflow flag Ovf is
// only implemented when ACC_EXEC_OVF_EN is defined; otherwise it reads 0.
module acc_execute
  import acc_pkg::*;
#(
  parameter logic [15:0] SP_INIT = SP_INIT_DEFAULT,
  parameter logic [15:0] PC_INIT = PC_INIT_DEFAULT
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] IR,
  input  logic [15:0] MDR,
  input  logic [15:0] IOIn,
  input  logic [1:0]  PCSrc,
  input  logic [1:0]  ALUSrcA,
  input  logic [2:0]  ALUSrcB,
  input  logic [1:0]  ALUOp,
  input  logic [2:0]  ACCSrc,
  input  logic        ACCWrite,
  input  logic        SPWrite,
  input  logic [1:0]  PCWrite,
  input  logic [1:0]  Branch,
  input  logic [1:0]  BneOrBeq,
  output logic [15:0] PC,
  output logic [15:0] ACC,
  output logic [15:0] SP,
  output logic [15:0] ALUOut,
  output logic        Zero,
  output logic        Ovf
);

  logic [15:0] r_pc;
  logic [15:0] r_acc;
  logic [15:0] r_sp;
  logic [15:0] r_aluout;
  logic        r_zero;
  logic        r_lt;

  logic [15:0] w_alu_a;
  logic [15:0] w_alu_b;
  logic [15:0] w_alu_r;
  logic        w_alu_lt;
  logic        w_alu_ovf;
  logic        w_r_is_zero;
  logic [15:0] w_acc_d;
  logic [15:0] w_pc_src;
  logic        w_branch_taken;
  logic        w_pc_we;
  logic        w_unused;

  // ALU A operand mux
  always_comb begin
    w_alu_a = 16'h0000;
    unique case (ALUSrcA)
      SRCA_PC:   w_alu_a = r_pc;
      SRCA_ACC:  w_alu_a = r_acc;
      SRCA_SP:   w_alu_a = r_sp;
      SRCA_ZERO: w_alu_a = 16'h0000;
      default:   w_alu_a = 16'h0000;
    endcase
  end

  // ALU B operand mux; immediates come from IR[9:0]
  always_comb begin
    w_alu_b = 16'h0000;
    case (ALUSrcB)
      SRCB_MDR:     w_alu_b = MDR;
      SRCB_TWO:     w_alu_b = 16'h0002;
      SRCB_SEXT:    w_alu_b = sext10(IR[9:0]);
      SRCB_ZEXT:    w_alu_b = {6'b0, IR[9:0]};
      SRCB_HI:      w_alu_b = {IR[9:0], 6'b0};
      SRCB_SEXT_SH: w_alu_b = {sext10(IR[9:0]), 1'b0} >> 0 == 0 ? 16'h0000
                                : sext10(IR[9:0]) << 1;
      default:      w_alu_b = 16'h0000;
    endcase
  end

  acc_alu u_alu (
    .a   (w_alu_a),
    .b   (w_alu_b),
    .op  (ALUOp),
    .r   (w_alu_r),
    .lt  (w_alu_lt),
    .ovf (w_alu_ovf)
  );

  // Zero detect on this cycle's result, shared by the Zero register and branch test
  always_comb begin
    w_r_is_zero = (w_alu_r == 16'h0000);
  end

  // ACC next value; ACCSrc=0 deliberately reads the previous cycle's ALUOut
  always_comb begin
    w_acc_d = r_acc;
    if (ACCWrite) begin
      case (ACCSrc)
        ACCSRC_ALUOUT: w_acc_d = r_aluout;
        ACCSRC_MDR:    w_acc_d = MDR;
        ACCSRC_IO:     w_acc_d = IOIn;
        ACCSRC_LT:     w_acc_d = {15'b0, r_lt};
        ACCSRC_R:      w_acc_d = w_alu_r;
        default:       w_acc_d = r_acc;
      endcase
    end
  end

  // Next-PC source; the jump target keeps PC[15:11] and word-aligns IR[9:0]
  always_comb begin
    w_pc_src = r_pc;
    unique case (PCSrc)
      PCSRC_R:      w_pc_src = w_alu_r;
      PCSRC_ALUOUT: w_pc_src = r_aluout;
      PCSRC_JUMP:   w_pc_src = {r_pc[15:11], IR[9:0], 1'b0};
      PCSRC_ACC:    w_pc_src = r_acc;
      default:      w_pc_src = r_pc;
    endcase
  end

  // PC write enable; branch test uses the combinational result, not registered Zero
  always_comb begin
    w_branch_taken = Branch[0] && (BneOrBeq[0] ? !w_r_is_zero : w_r_is_zero);
    w_pc_we        = PCWrite[0] || w_branch_taken;
  end

  // Architectural state update with asynchronous clear
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_pc     <= PC_INIT;
      r_acc    <= 16'h0000;
      r_sp     <= SP_INIT;
      r_aluout <= 16'h0000;
      r_zero   <= 1'b0;
      r_lt     <= 1'b0;
    end else begin
      if (w_pc_we) begin
        r_pc <= w_pc_src;
      end
      if (SPWrite) begin
        r_sp <= w_alu_r;
      end
      r_acc    <= w_acc_d;
      r_aluout <= w_alu_r;
      r_zero   <= w_r_is_zero;
      r_lt     <= w_alu_lt;
    end
  end

`ifdef ACC_EXEC_OVF_EN
  logic r_ovf;

  // Sticky overflow, set only by arithmetic results written into ACC
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_ovf <= 1'b0;
    end else if (w_alu_ovf && ACCWrite &&
                 (ACCSrc == ACCSRC_ALUOUT || ACCSrc == ACCSRC_R)) begin
      r_ovf <= 1'b1;
    end
  end

  assign Ovf = r_ovf;
`else
  assign Ovf = 1'b0;
`endif

  // Upper control bits and IR opcode bits are not decoded in this stage
  assign w_unused = ^{PCWrite[1], Branch[1], BneOrBeq[1], IR[15:10], w_alu_ovf};

  assign PC     = r_pc;
  assign ACC    = r_acc;
  assign SP     = r_sp;
  assign ALUOut = r_aluout;
  assign Zero   = r_zero;

endmodule

// File: tb/tb_acc_execute.sv
// Directed self-checking bench for acc_execute. Expected values are queued as
// each step is driven and compared after the clock edge that produces them.
module tb_acc_execute;

  logic        CLK;
  logic        Reset;
  logic [15:0] IR;
  logic [15:0] MDR;
  logic [15:0] IOIn;
  logic [1:0]  PCSrc;
  logic [1:0]  ALUSrcA;
  logic [2:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic [2:0]  ACCSrc;
  logic        ACCWrite;
  logic        SPWrite;
  logic [1:0]  PCWrite;
  logic [1:0]  Branch;
  logic [1:0]  BneOrBeq;
  logic [15:0] PC;
  logic [15:0] ACC;
  logic [15:0] SP;
  logic [15:0] ALUOut;
  logic        Zero;
  logic        Ovf;

`ifdef ACC_EXEC_OVF_EN
  localparam logic [15:0] OVF_EXP = 16'h0001;
`else
  localparam logic [15:0] OVF_EXP = 16'h0000;
`endif

  localparam int SEL_PC = 0, SEL_ACC = 1, SEL_SP = 2, SEL_ALUOUT = 3, SEL_ZERO = 4, SEL_OVF = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  acc_execute dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .IR       (IR),
    .MDR      (MDR),
    .IOIn     (IOIn),
    .PCSrc    (PCSrc),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .ACCSrc   (ACCSrc),
    .ACCWrite (ACCWrite),
    .SPWrite  (SPWrite),
    .PCWrite  (PCWrite),
    .Branch   (Branch),
    .BneOrBeq (BneOrBeq),
    .PC       (PC),
    .ACC      (ACC),
    .SP       (SP),
    .ALUOut   (ALUOut),
    .Zero     (Zero),
    .Ovf      (Ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      SEL_PC:     return PC;
      SEL_ACC:    return ACC;
      SEL_SP:     return SP;
      SEL_ALUOUT: return ALUOut;
      SEL_ZERO:   return {15'b0, Zero};
      default:    return {15'b0, Ovf};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [15:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = observe(e.sel);
      n_cmp++;
      assert (got === e.val) else begin
        n_mis++;
        $error("FAIL %s: observed %h expected %h", e.tag, got, e.val);
      end
    end
  endtask

  // Zero-result idle: A=0, B=0, add, every write disabled
  task automatic idle();
    ALUSrcA = 2'd3; ALUSrcB = 3'd6; ALUOp = 2'd0; ACCSrc = 3'd5; PCSrc = 2'd0;
    ACCWrite = 1'b0; SPWrite = 1'b0; PCWrite = 2'b00; Branch = 2'b00; BneOrBeq = 2'b00;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic set_acc(input logic [15:0] v);
    idle(); IOIn = v; ACCSrc = 3'd2; ACCWrite = 1'b1;
    step(); idle();
  endtask

  // PC <= r with r = 0 + MDR
  task automatic set_pc(input logic [15:0] v);
    idle(); MDR = v; ALUSrcB = 3'd0; PCSrc = 2'd0; PCWrite = 2'b01;
    step(); idle();
  endtask

  task automatic set_aluout(input logic [15:0] v);
    idle(); MDR = v; ALUSrcB = 3'd0;
    step(); idle();
  endtask

  task automatic push_reset_vals(input string tag);
    push({tag, "_pc"}, SEL_PC, 16'h0000);
    push({tag, "_acc"}, SEL_ACC, 16'h0000);
    push({tag, "_sp"}, SEL_SP, 16'h07fe);
    push({tag, "_aluout"}, SEL_ALUOUT, 16'h0000);
    push({tag, "_zero"}, SEL_ZERO, 16'h0000);
    push({tag, "_ovf"}, SEL_OVF, 16'h0000);
  endtask

  initial begin
    Reset = 1'b0; IR = 16'h0000; MDR = 16'h0000; IOIn = 16'h0000;
    idle();
    repeat (2) @(posedge CLK);
    #1;
    push_reset_vals("por");
    check_all();
    #2 Reset = 1'b1;

    // Load every register with non-reset values, then reset mid-cycle
    IOIn = 16'h1234; ACCSrc = 3'd2; ACCWrite = 1'b1;
    MDR = 16'h5555; ALUSrcB = 3'd0; SPWrite = 1'b1; PCWrite = 2'b01; PCSrc = 2'd0;
    push("pre_acc", SEL_ACC, 16'h1234);
    push("pre_sp", SEL_SP, 16'h5555);
    push("pre_pc", SEL_PC, 16'h5555);
    push("pre_aluout", SEL_ALUOUT, 16'h5555);
    push("pre_zero", SEL_ZERO, 16'h0000);
    step(); idle();
    #3 Reset = 1'b0;
    #1;
    push_reset_vals("mid_rst");
    check_all();
    #2 Reset = 1'b1;

    // Idle cycle: zero result registers Zero=1
    push("idle_zero", SEL_ZERO, 16'h0001);
    step();

    // Fetch increment and wrap
    set_pc(16'h0010);
    ALUSrcA = 2'd0; ALUSrcB = 3'd1; ALUOp = 2'd0; PCSrc = 2'd0; PCWrite = 2'b01;
    push("fetch_pc", SEL_PC, 16'h0012);
    push("fetch_aluout", SEL_ALUOUT, 16'h0012);
    push("fetch_zero", SEL_ZERO, 16'h0000);
    step(); idle();
    set_pc(16'hfffe);
    ALUSrcA = 2'd0; ALUSrcB = 3'd1; ALUOp = 2'd0; PCSrc = 2'd0; PCWrite = 2'b01;
    push("wrap_pc", SEL_PC, 16'h0000);
    push("wrap_zero", SEL_ZERO, 16'h0001);
    step(); idle();

    // addi with sign- and zero-extended immediates
    set_acc(16'h0005);
    IR = 16'h03ff; ALUSrcA = 2'd1; ALUSrcB = 3'd2; ALUOp = 2'd0; ACCSrc = 3'd4; ACCWrite = 1'b1;
    push("addi_sext", SEL_ACC, 16'h0004);
    step();
    ALUSrcB = 3'd3;
    push("addi_zext", SEL_ACC, 16'h0403);
    step(); idle();

    // Signed overflow wraps; sticky flag only with the feature built
    set_acc(16'h7fff);
    IR = 16'h0001; ALUSrcA = 2'd1; ALUSrcB = 3'd2; ALUOp = 2'd0; ACCSrc = 3'd4; ACCWrite = 1'b1;
    push("ovf_acc", SEL_ACC, 16'h8000);
    push("ovf_set", SEL_OVF, OVF_EXP);
    step(); idle();
    push("ovf_sticky", SEL_OVF, OVF_EXP);
    step();

    // slt via registered lt
    set_acc(16'hfffe);
    MDR = 16'h0003; ALUSrcA = 2'd1; ALUSrcB = 3'd0; ALUOp = 2'd1;
    push("slt1_aluout", SEL_ALUOUT, 16'hfffb);
    step(); idle();
    ACCSrc = 3'd3; ACCWrite = 1'b1;
    push("slt1_acc", SEL_ACC, 16'h0001);
    step();
    set_acc(16'h0003);
    MDR = 16'hfffe; ALUSrcA = 2'd1; ALUSrcB = 3'd0; ALUOp = 2'd1;
    push("slt2_aluout", SEL_ALUOUT, 16'h0005);
    step(); idle();
    ACCSrc = 3'd3; ACCWrite = 1'b1;
    push("slt2_acc", SEL_ACC, 16'h0000);
    step();
    // Difference overflows positive, but signed compare still says less-than
    set_acc(16'h8000);
    MDR = 16'h0001; ALUSrcA = 2'd1; ALUSrcB = 3'd0; ALUOp = 2'd1;
    push("slt3_aluout", SEL_ALUOUT, 16'h7fff);
    step(); idle();
    ACCSrc = 3'd3; ACCWrite = 1'b1;
    push("slt3_acc", SEL_ACC, 16'h0001);
    step(); idle();

    // ACCSrc=0 takes last cycle's ALUOut, not this cycle's result
    MDR = 16'habcd; ALUSrcB = 3'd0;
    step();
    MDR = 16'h1111; ACCSrc = 3'd0; ACCWrite = 1'b1;
    push("accsrc0_acc", SEL_ACC, 16'habcd);
    push("accsrc0_aluout", SEL_ALUOUT, 16'h1111);
    step(); idle();
    MDR = 16'h2468; ACCSrc = 3'd1; ACCWrite = 1'b1;
    push("accsrc_mdr", SEL_ACC, 16'h2468);
    step(); idle();
    MDR = 16'h9999; ALUSrcB = 3'd0; ACCSrc = 3'd6; ACCWrite = 1'b1;
    push("accsrc_hold", SEL_ACC, 16'h2468);
    push("hold_aluout", SEL_ALUOUT, 16'h9999);
    step(); idle();

    // Logic ops and shifted immediates
    set_acc(16'hf0f0);
    MDR = 16'h0ff0; ALUSrcA = 2'd1; ALUSrcB = 3'd0; ALUOp = 2'd2; ACCSrc = 3'd4; ACCWrite = 1'b1;
    push("or_acc", SEL_ACC, 16'hfff0);
    step();
    MDR = 16'h0f0f; ALUOp = 2'd3;
    push("and_acc", SEL_ACC, 16'h0f00);
    step(); idle();
    IR = 16'h0155; ALUSrcB = 3'd4; ACCSrc = 3'd4; ACCWrite = 1'b1;
    push("imm_hi", SEL_ACC, 16'h5540);
    step();
    IR = 16'h02aa; ALUSrcB = 3'd5;
    push("imm_sext_sh", SEL_ACC, 16'hfd54);
    step(); idle();

    // Branches: ALUOut holds the target, compare ACC against MDR
    set_pc(16'h0100);
    MDR = 16'h0040; ALUSrcB = 3'd0; IOIn = 16'h0007; ACCSrc = 3'd2; ACCWrite = 1'b1;
    step(); idle();
    MDR = 16'h0007; ALUSrcA = 2'd1; ALUSrcB = 3'd0; ALUOp = 2'd1;
    Branch = 2'b01; PCSrc = 2'd1; BneOrBeq = 2'b01;
    push("bne_not_taken", SEL_PC, 16'h0100);
    step();
    set_aluout(16'h0040);
    MDR = 16'h0007; ALUSrcA = 2'd1; ALUSrcB = 3'd0; ALUOp = 2'd1;
    Branch = 2'b01; PCSrc = 2'd1; BneOrBeq = 2'b00;
    push("beq_taken", SEL_PC, 16'h0040);
    step();
    set_aluout(16'h0080);
    MDR = 16'h0007; ALUSrcA = 2'd1; ALUSrcB = 3'd0; ALUOp = 2'd1;
    Branch = 2'b01; PCSrc = 2'd1; BneOrBeq = 2'b01; PCWrite = 2'b01;
    push("pcwrite_override", SEL_PC, 16'h0080);
    step();
    set_aluout(16'h00c0);
    MDR = 16'h0005; ALUSrcA = 2'd1; ALUSrcB = 3'd0; ALUOp = 2'd1;
    Branch = 2'b01; PCSrc = 2'd1; BneOrBeq = 2'b01;
    push("bne_taken", SEL_PC, 16'h00c0);
    step();
    set_aluout(16'h0200);
    MDR = 16'h0005; ALUSrcA = 2'd1; ALUSrcB = 3'd0; ALUOp = 2'd1;
    Branch = 2'b01; PCSrc = 2'd1; BneOrBeq = 2'b00;
    push("beq_not_taken", SEL_PC, 16'h00c0);
    step();
    set_aluout(16'h0300);
    PCWrite = 2'b10; Branch = 2'b10; PCSrc = 2'd1;
    push("upper_bits_ignored", SEL_PC, 16'h00c0);
    step(); idle();
    PCSrc = 2'd3; PCWrite = 2'b01;
    push("pcsrc_acc", SEL_PC, 16'h0007);
    step(); idle();

    // Jump with simultaneous SP decrement
    set_pc(16'ha000);
    IR = 16'h0155; PCSrc = 2'd2; PCWrite = 2'b01;
    ALUSrcA = 2'd2; ALUSrcB = 3'd1; ALUOp = 2'd1; SPWrite = 1'b1;
    push("jump_pc", SEL_PC, 16'ha2aa);
    push("jump_sp", SEL_SP, 16'h07fc);
    push("jump_aluout", SEL_ALUOUT, 16'h07fc);
    step(); idle();
    push("final_ovf", SEL_OVF, OVF_EXP);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/acc_execute.md
# acc_execute

Execute/writeback stage of the accumulator processor, sitting directly downstream of the memory/control stage. It consumes that stage's control word (PCSrc, ALUSrcA/B, ALUOp, ACCSrc, ACCWrite, SPWrite, PCWrite, Branch, BneOrBeq), the latched instruction (IR) and the memory data register (MDR). It owns the architectural PC, ACC and SP registers, the ALU and the ALUOut register, and feeds PC, ACC and ALUOut back to the memory stage.

## Interface
- SP_INIT, 16'h07fe, reset value of SP
- PC_INIT, 16'h0000, reset value of PC
- CLK  in  1  single clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-low; clears all state immediately
- IR  in  16  latched instruction; IR[9:0] is the immediate/target field
- MDR  in  16  memory data register
- IOIn  in  16  input-port value
- PCSrc  in  2  next-PC select
- ALUSrcA  in  2  ALU A select
- ALUSrcB  in  3  ALU B select
- ALUOp  in  2  ALU function
- ACCSrc  in  3  ACC write-data select
- ACCWrite, SPWrite  in  1 each  register write enables
- PCWrite, Branch, BneOrBeq  in  2 each  PC write control; only bit 0 is used
- PC, ACC, SP, ALUOut  out  16 each  architectural registers
- Zero  out  1  registered: last ALU result == 0
- Ovf  out  1  sticky signed overflow flag (ACC_EXEC_OVF_EN only)

## Operation
- ALUSrcA: 0 PC, 1 ACC, 2 SP, 3 16'h0000.
- ALUSrcB:
  - 0 MDR
  - 1 16'h0002
  - 2 sign-extend IR[9:0]
  - 3 zero-extend IR[9:0]
  - 4 {IR[9:0], 6'b0}
  - 5 sign-extend IR[9:0] << 1
  - 6 and 7 give 16'h0000
- ALUOp: 0 A+B, 1 A−B, 2 A|B, 3 A&B. All arithmetic is 16-bit modulo 2^16 and wraps silently.
- The ALU result `r` is combinational. ALUOut <= r every cycle. Zero <= (r==0) every cycle. A lt register <= signed(A) < signed(B) every cycle, computed from full-precision compare, not the sign of r.
- ACCSrc, applied when ACCWrite=1:
  - 0 ALUOut
  - 1 MDR
  - 2 IOIn
  - 3 {15'b0, lt}
  - 4 r
  - 5..7 hold ACC
- SPWrite=1: SP <= r.
- PCSrc: 0 r, 1 ALUOut, 2 {PC[15:11], IR[9:0], 1'b0}, 3 ACC.
- PC update:
  - PCWrite[0]=1: write PC unconditionally.
  - Else if Branch[0]=1: write PC only if the condition holds. Condition is (r==0) when BneOrBeq[0]=0 (beq) and (r!=0) when BneOrBeq[0]=1 (bne).
  - The condition uses this cycle's combinational r, not the registered Zero.
- Simultaneous writes: ACC, SP and PC may all update in the same cycle, each from its own select. Unconditional PC write overrides the branch.
- Reset low: PC=PC_INIT, ACC=0, SP=SP_INIT, ALUOut=0, Zero=0, lt=0, Ovf=0. This applies mid-instruction as well; no partial update survives.

## Timing
- Every register updates on the CLK edge following its enable; there is no internal wait state.
- A write enable asserted in cycle n makes the new value visible on the output in cycle n+1.
- ALUOut and Zero have 1-cycle latency from the operands. ACCSrc=0 therefore reads the previous cycle's result.
- The branch decision and PC write complete in the same cycle as the compare.
- Reset assertion is asynchronous. Deassertion is sampled at the next CLK edge; the first update occurs on that edge.

## Configuration
- ACC_EXEC_OVF_EN defined: Ovf is set when ALUOp is 0 or 1 and signed overflow occurs while ACCWrite=1 with ACCSrc 0 or 4. Once set it stays set until Reset.
- Undefined: Ovf is tied to 0 and no overflow logic is built.

## Structure
- Package acc_pkg holds the encoding localparams for ALUSrcA, ALUSrcB, ALUOp, ACCSrc and PCSrc, plus the SP_INIT and PC_INIT defaults.
- One combinational sub-module, acc_alu. Inputs: a, b, op. Outputs: r, lt, ovf. All registers live in acc_execute.

## Test plan
- Reset low mid-run with ACC=16'h1234 -> immediately PC=0000, ACC=0000, SP=07fe, ALUOut=0000, Zero=0.
- Fetch increment: ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSrc=0, PCWrite=1 from PC=0010 -> PC=0012 next cycle. From PC=fffe -> PC=0000 (wrap).
- addi: ACC=0005, IR[9:0]=10'h3ff, ALUSrcB=2, ALUOp=0, ACCSrc=4 -> ACC=0004. With ACC_EXEC_OVF_EN: ACC=7fff, +1 -> ACC=8000 and Ovf=1, which stays 1.
- slt: ACC=fffe (−2), MDR=0003, ALUOp=1. Next cycle ACCSrc=3, ACCWrite=1 -> ACC=0001. Repeat with ACC=0003, MDR=fffe -> ACC=0000.
- beq/bne: ALUOut=0040, ACC=MDR=0007, Branch=1, PCSrc=1, ALUOp=1. BneOrBeq=0 -> PC=0040. BneOrBeq=1 -> PC unchanged. With PCWrite=1 also set -> PC written regardless.
- Jump and SP: IR[9:0]=10'h155, PC=a000, PCSrc=2, PCWrite=1 -> PC=a2aa. In the same cycle ALUSrcA=2, ALUSrcB=1, ALUOp=1, SPWrite=1 -> SP=07fc. Note PCSrc=2 does not use r, so the SP update does not disturb the jump target.
